// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - assembles 3-byte UART commands into 21-bit words and echoes accepted bytes
module uart_cmd_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 20000,
  parameter int ECHO       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [3*(DATA_WIDTH-1)-1:0] cmd_data,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [7:0]                  err_count
);

  localparam int PW = DATA_WIDTH - 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GOT1, GOT2} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           b0_q, b0_d, b1_q, b1_d;
  logic [15:0]             tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0]   tx_data_d;
  logic                    tx_valid_d;
  logic [3*PW-1:0]         cmd_data_d;
  logic                    cmd_valid_d;
  logic [7:0]              err_d;
  logic                    err_inc;
  logic                    accept;
  logic                    start_byte;

  // A finished frame cannot be completed while the previous command is still unconsumed.
  assign rx_ready = !rst
                  && !(state_q == GOT2 && cmd_valid && !cmd_ready)
                  && ((ECHO == 0) || !tx_valid || tx_ready);
  assign accept     = rx_valid && rx_ready;
  assign start_byte = rx_data[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      b0_q      <= '0;
      b1_q      <= '0;
      tmr_q     <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      tmr_q     <= tmr_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      cmd_data  <= cmd_data_d;
      cmd_valid <= cmd_valid_d;
      err_count <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    tmr_d       = tmr_q;
    err_inc     = 1'b0;
    tx_valid_d  = tx_valid && !tx_ready;
    tx_data_d   = tx_data;
    cmd_valid_d = cmd_valid && !cmd_ready;
    cmd_data_d  = cmd_data;

    if (accept) begin
      tmr_d = '0;
      if (ECHO != 0) begin
        tx_valid_d = 1'b1;
        tx_data_d  = rx_data;
      end
      case (state_q)
        IDLE: begin
          if (start_byte) begin
            b0_d    = rx_data[PW-1:0];
            state_d = GOT1;
          end else begin
            err_inc = 1'b1;
          end
        end
        GOT1: begin
          if (start_byte) begin
            b0_d    = rx_data[PW-1:0];
            err_inc = 1'b1;
          end else begin
            b1_d    = rx_data[PW-1:0];
            state_d = GOT2;
          end
        end
        default: begin
          if (start_byte) begin
            b0_d    = rx_data[PW-1:0];
            state_d = GOT1;
            err_inc = 1'b1;
          end else begin
            cmd_data_d  = {b0_q, b1_q, rx_data[PW-1:0]};
            cmd_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      endcase
    end else if (state_q == IDLE) begin
      tmr_d = '0;
    end else if (tmr_q == TMO_LAST) begin
      state_d = IDLE;
      tmr_d   = '0;
      err_inc = 1'b1;
    end else begin
      tmr_d = tmr_q + 16'd1;
    end

    err_d = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - table, directed and randomized checks of uart_cmd_framer against a frame-queue model
module tb_uart_cmd_framer;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_ready, tx_valid, tx_ready, cmd_valid, cmd_ready;
  logic [7:0]  rx_data, tx_data, err_count;
  logic [20:0] cmd_data;

  always #5 clk = ~clk;

  uart_cmd_framer #(.DATA_WIDTH(8), .TIMEOUT(TMO), .ECHO(1)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: partial frame as a byte queue, timeout from accept timestamps.
  logic [7:0]  frm[$];
  logic        m_txv, m_cv, m_acc;
  logic [7:0]  m_txd;
  logic [20:0] m_cd;
  int          m_err, cyc, last_acc;
  logic [7:0]  acc_q[$], echo_q[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        cv;
    logic [20:0] cd;
    logic [7:0]  err;
    logic        txv;
    logic [7:0]  txd;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    frm.delete();
    m_txv = 0; m_txd = 0; m_cv = 0; m_cd = 0; m_err = 0;
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic txr, input logic cr);
    logic exp_rdy;
    rst = r; rx_valid = v; rx_data = d; tx_ready = txr; cmd_ready = cr;
    @(negedge clk);
    if (r) model_reset();
    exp_rdy = !r && !(frm.size() == 2 && m_cv && !cr) && (!m_txv || txr);
    chk("rx_ready", rx_ready, exp_rdy);
    chk("tx_valid", tx_valid, m_txv);
    chk("tx_data", tx_data, m_txd);
    chk("cmd_valid", cmd_valid, m_cv);
    chk("cmd_data", cmd_data, m_cd);
    chk("err_count", err_count, m_err);
    if (tx_valid && txr) echo_q.push_back(tx_data);
    m_acc = v && exp_rdy;
    if (!r) begin
      if (m_cv && cr) m_cv = 0;
      if (m_acc) begin
        acc_q.push_back(d);
        m_txv = 1; m_txd = d; last_acc = cyc;
        if (d[7]) begin
          if (frm.size() != 0) bump_err();
          frm.delete();
          frm.push_back(d);
        end else if (frm.size() == 0) begin
          bump_err();
        end else if (frm.size() == 1) begin
          frm.push_back(d);
        end else begin
          m_cv = 1;
          m_cd = {frm[0][6:0], frm[1][6:0], d[6:0]};
          frm.delete();
        end
      end else begin
        if (m_txv && txr) m_txv = 0;
        if (frm.size() != 0 && cyc - last_acc == TMO) begin
          frm.delete();
          bump_err();
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 1, 1);
  endtask

  initial begin
    int stall_acc;
    logic saw_cv;
    cyc = 0; last_acc = 0;
    model_reset();
    rst = 1; rx_valid = 0; rx_data = 0; tx_ready = 1; cmd_ready = 1;

    tbl[0] = '{1'b1, 8'hC3, 1'b0, 21'h0,      8'd0, 1'b1, 8'hC3};
    tbl[1] = '{1'b1, 8'h12, 1'b0, 21'h0,      8'd0, 1'b1, 8'h12};
    tbl[2] = '{1'b1, 8'h34, 1'b1, 21'h10C934, 8'd0, 1'b1, 8'h34};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 21'h0,      8'd0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 21'h0,      8'd1, 1'b1, 8'h05};
    tbl[5] = '{1'b1, 8'h90, 1'b0, 21'h0,      8'd1, 1'b1, 8'h90};
    tbl[6] = '{1'b1, 8'h91, 1'b0, 21'h0,      8'd2, 1'b1, 8'h91};
    tbl[7] = '{1'b1, 8'h00, 1'b0, 21'h0,      8'd2, 1'b1, 8'h00};
    tbl[8] = '{1'b1, 8'h00, 1'b1, 21'h044000, 8'd2, 1'b1, 8'h00};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 21'h0,      8'd2, 1'b0, 8'h00};

    do_reset();
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_err", err_count, 0);

    // Basic command, stray byte and resync
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].v, tbl[i].d, 1, 1);
      chk("tbl_cmd_valid", cmd_valid, tbl[i].cv);
      chk("tbl_err", err_count, tbl[i].err);
      chk("tbl_tx_valid", tx_valid, tbl[i].txv);
      if (tbl[i].cv) chk("tbl_cmd_data", cmd_data, tbl[i].cd);
      if (tbl[i].txv) chk("tbl_tx_data", tx_data, tbl[i].txd);
    end

    // Command held while decoder stalls; third byte waits, then no bubble
    do_reset();
    step(0, 1, 8'h80, 1, 0);
    step(0, 1, 8'h05, 1, 0);
    step(0, 1, 8'h7F, 1, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 8'h00, 1, 0);
    chk("t2_held_valid", cmd_valid, 1);
    chk("t2_held_data", cmd_data, 21'h0002FF);
    step(0, 1, 8'h81, 1, 0);
    step(0, 1, 8'h01, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h02, 1, 0);
    chk("t2_blocked", rx_ready, 0);
    step(0, 1, 8'h02, 1, 1);
    chk("t2_nobubble_valid", cmd_valid, 1);
    chk("t2_next_data", cmd_data, 21'h004082);
    step(0, 0, 8'h00, 1, 1);
    chk("t2_consumed", cmd_valid, 0);

    // Timeout boundary: last cycle still accepted, one more discards the frame
    do_reset();
    step(0, 1, 8'hA0, 1, 1);
    step(0, 1, 8'h01, 1, 1);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 8'h00, 1, 1);
    step(0, 1, 8'h02, 1, 1);
    chk("t4_edge_valid", cmd_valid, 1);
    chk("t4_edge_data", cmd_data, 21'h080082);
    chk("t4_edge_err", err_count, 0);
    do_reset();
    saw_cv = 0;
    step(0, 1, 8'hA0, 1, 1);
    step(0, 1, 8'h01, 1, 1);
    for (int i = 0; i < TMO; i++) begin
      step(0, 0, 8'h00, 1, 1);
      saw_cv |= cmd_valid;
    end
    step(0, 1, 8'h7F, 1, 1);
    saw_cv |= cmd_valid;
    step(0, 0, 8'h00, 1, 1);
    chk("t4_err", err_count, 2);
    chk("t4_no_cmd", saw_cv, 0);

    // Echo back-pressure: one accept then stall, stream intact after release
    do_reset();
    acc_q.delete(); echo_q.delete();
    stall_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h85, 0, 1);
      stall_acc += int'(m_acc);
    end
    chk("t5_stall_accepts", stall_acc, 1);
    begin
      logic [7:0] seq[6];
      seq = '{8'h11, 8'h22, 8'h86, 8'h33, 8'h44, 8'h05};
      foreach (seq[k]) begin
        int guard = 0;
        do begin
          step(0, 1, seq[k], 1'($urandom_range(0, 1)), 1);
          guard++;
        end while (!m_acc && guard < 50);
        chk("t5_accept_bound", int'(m_acc), 1);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 1);
    chk("t5_echo_count", echo_q.size(), acc_q.size());
    foreach (acc_q[k]) if (k < echo_q.size()) chk("t5_echo_byte", echo_q[k], acc_q[k]);

    // Reset mid-frame
    do_reset();
    step(0, 1, 8'hC0, 1, 1);
    step(0, 1, 8'h11, 1, 1);
    step(1, 0, 8'h00, 1, 1);
    chk("t6_rst_txv", tx_valid, 0);
    chk("t6_rst_cv", cmd_valid, 0);
    chk("t6_rst_rdy", rx_ready, 0);
    step(0, 1, 8'h11, 1, 1);
    step(0, 1, 8'h22, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    chk("t6_err", err_count, 2);
    chk("t6_no_cmd", cmd_valid, 0);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 1, 8'h05, 1, 1);
    chk("sat_err", err_count, 255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 2) != 0) d[7] = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        int gap = TMO - 1 + int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) step(0, 0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, d,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
